// File: rtl/minv_pkg.sv
// Shared constants, flag codes and result-reader state encoding for the modular-inverse datapath.
package minv_pkg;

  localparam int MINV_DW = 16;
  localparam int MINV_NW = 16;

  // minv_flag codes reported alongside each result
  localparam logic [1:0] MINV_FLAG_X1  = 2'b00;
  localparam logic [1:0] MINV_FLAG_X2  = 2'b01;
  localparam logic [1:0] MINV_FLAG_ADJ = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/minv_result_reader.sv
// Snapshots u/minv_flag on a minv_rdy rising edge and streams it as NW words of DW bits.
// Latency: first word valid one cycle after the edge, then one word per accepted cycle.
// Backpressure: word held while dout_rdy low. MINV_RD_MSW_FIRST_EN selects MSW-first order.
module minv_result_reader
  import minv_pkg::*;
#(
  parameter int DW = MINV_DW,
  parameter int NW = MINV_NW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             minv_rdy,
  input  logic [DW*NW-1:0] u,
  input  logic [1:0]       minv_flag,
  output logic [DW-1:0]    dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             dout_last,
  output logic [1:0]       res_flag,
  output logic             busy,
  output logic             rd_done
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  rd_state_t        state, state_nxt;
  logic [DW*NW-1:0] res_buf;
  logic [CW-1:0]    cnt;
  logic             rdy_q;
  logic             edge_det;
  logic             accept;
  logic             last_word;
  logic [DW-1:0]    cur_word;

  assign edge_det  = minv_rdy & ~rdy_q;
  assign last_word = (cnt == LAST_IDX);
  assign accept    = dout_vld & dout_rdy;

`ifdef MINV_RD_MSW_FIRST_EN
  assign cur_word = res_buf[DW*NW-1 -: DW];
`else
  assign cur_word = res_buf[DW-1:0];
`endif

  // Output word is forced to zero whenever nothing is being presented
  assign dout      = dout_vld ? cur_word : '0;
  assign dout_last = dout_vld & last_word;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    dout_vld  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: if (edge_det) state_nxt = SEND;
      SEND: begin
        dout_vld = 1'b1;
        if (dout_rdy && last_word) state_nxt = DONE;
      end
      DONE: begin
        rd_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      cnt      <= '0;
      res_buf  <= '0;
      res_flag <= 2'b00;
    end else begin
      state <= state_nxt;
      // Tracks in every state so a level still high on return to IDLE does not retrigger
      rdy_q <= minv_rdy;
      if (state == IDLE && edge_det) begin
        res_buf  <= u;
        res_flag <= minv_flag;
        cnt      <= '0;
      end else if (accept) begin
`ifdef MINV_RD_MSW_FIRST_EN
        res_buf <= res_buf << DW;
`else
        res_buf <= res_buf >> DW;
`endif
        if (!last_word) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_minv_result_reader.sv
// Randomized scoreboard bench for minv_result_reader: expected words queued at capture, monitor pops on accept.
module tb_minv_result_reader;
  import minv_pkg::*;

  localparam int DW = 16;
  localparam int NW = 16;

  typedef struct packed {
    logic [DW-1:0] w;
    logic          last;
    logic [1:0]    f;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             minv_rdy = 1'b0;
  logic [DW*NW-1:0] u = '0;
  logic [1:0]       minv_flag = 2'b00;
  logic [DW-1:0]    dout;
  logic             dout_vld;
  logic             dout_rdy = 1'b0;
  logic             dout_last;
  logic [1:0]       res_flag;
  logic             busy;
  logic             rd_done;

  minv_result_reader #(.DW(DW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .minv_rdy(minv_rdy), .u(u), .minv_flag(minv_flag),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_last(dout_last),
    .res_flag(res_flag), .busy(busy), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   acc_cnt = 0;
  int   rdy_mode = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host-side ready generator: always, random, or the 1,0,0 repeating pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0: dout_rdy = 1'b1;
        1: dout_rdy = ($urandom_range(0, 1) == 1);
        default: dout_rdy = (cyc % 3 == 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks per-cycle invariants
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;
  logic          prev_last = 1'b0;
  logic          exp_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        chk("rd_done", rd_done, exp_done);
        exp_done = 1'b0;
        if (!dout_vld) chk("dout_idle_zero", dout, 0);
        if (prev_stall && dout_vld) begin
          chk("stall_dout_stable", dout, prev_dout);
          chk("stall_last_stable", dout_last, prev_last);
        end
        if (dout_vld && dout_rdy) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h with empty scoreboard at cycle %0d", dout, cyc);
          end else begin
            e = sb.pop_front();
            chk("word", dout, e.w);
            chk("last", dout_last, e.last);
            chk("res_flag", res_flag, e.f);
            exp_done = e.last;
            acc_cnt++;
          end
        end
        prev_stall = dout_vld && !dout_rdy;
        prev_dout  = dout;
        prev_last  = dout_last;
      end
    end
  end

  function automatic logic [DW-1:0] model_word(input logic [DW*NW-1:0] uv, input int i);
`ifdef MINV_RD_MSW_FIRST_EN
    return uv[(NW-1-i)*DW +: DW];
`else
    return uv[i*DW +: DW];
`endif
  endfunction

  function automatic logic [DW*NW-1:0] rand_u();
    logic [DW*NW-1:0] r;
    for (int k = 0; k < DW*NW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] rand_flag();
    case ($urandom_range(0, 2))
      0: return MINV_FLAG_X1;
      1: return MINV_FLAG_X2;
      default: return MINV_FLAG_ADJ;
    endcase
  endfunction

  task automatic run_stream(input logic [DW*NW-1:0] uv, input logic [1:0] fv, input int rmode,
                            input bit glitch, input bit do_rst, input bit chk_lat);
    exp_t e;
    int   guard;
    rdy_mode  = rmode;
    minv_rdy  = 1'b0;
    u         = uv;
    minv_flag = fv;
    tick();
    tick();
    chk("busy_before_edge", busy, 0);
    for (int i = 0; i < NW; i++) begin
      e.w = model_word(uv, i);
      e.last = (i == NW - 1);
      e.f = fv;
      sb.push_back(e);
    end
    acc_cnt  = 0;
    minv_rdy = 1'b1;
    tick();
    // Inputs change after capture; the stream must not notice
    u         = rand_u();
    minv_flag = ~fv;
    if (chk_lat) begin
      for (int k = 1; k <= NW + 2; k++) begin
        @(negedge clk);
        chk("lat_vld", dout_vld, (k <= NW) ? 1 : 0);
        chk("lat_busy", busy, (k <= NW + 1) ? 1 : 0);
        chk("lat_done", rd_done, (k == NW + 1) ? 1 : 0);
      end
      tick();
    end
    if (glitch) begin
      tick();
      tick();
      minv_rdy = 1'b0;
      tick();
      minv_rdy = 1'b1;
    end
    if (do_rst) begin
      guard = 0;
      while (acc_cnt < 7 && guard < 2000) begin
        tick();
        guard++;
      end
      chk("accepts_before_rst", acc_cnt, 7);
      rst      = 1'b1;
      minv_rdy = 1'b0;
      tick();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("rst_vld", dout_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", rd_done, 0);
      chk("rst_flag", res_flag, 0);
      tick();
      return;
    end
    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("stream_complete", sb.size(), 0);
    sb.delete();
    // minv_rdy still high: nothing may restart
    repeat (4) tick();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_vld", dout_vld, 0);
    chk("accept_count", acc_cnt, NW);
    tick();
  endtask

  initial begin
    logic [DW*NW-1:0] u_dir;
    logic [DW*NW-1:0] u_msw;
    u_dir = 256'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0_1357_9BDF_2468_FEDC;
    u_msw = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset_dout", dout, 0);
    chk("reset_vld", dout_vld, 0);
    chk("reset_last", dout_last, 0);
    chk("reset_flag", res_flag, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", rd_done, 0);
    tick();
    rst = 1'b0;
    tick();

    run_stream(u_dir, MINV_FLAG_X2, 0, 1'b0, 1'b0, 1'b1);
    run_stream(u_dir, MINV_FLAG_X2, 2, 1'b0, 1'b0, 1'b0);
    run_stream(u_dir, MINV_FLAG_ADJ, 0, 1'b1, 1'b0, 1'b0);
    run_stream(u_dir, MINV_FLAG_X2, 1, 1'b0, 1'b1, 1'b0);
    run_stream(u_dir, MINV_FLAG_X1, 0, 1'b0, 1'b0, 1'b1);
    run_stream(u_msw, MINV_FLAG_X2, 1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_stream(rand_u(), rand_flag(), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'b0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1);
  end

endmodule
